// File: rtl/freq_counter_multi.sv
// freq_counter_multi
//   Multi-channel frequency counter sharing one gate timer. Each channel has
//   its own input synchronizer, rising-edge detector and saturating counter.
//   The gate time is selected at runtime as 1 s, 100 ms, 10 ms or 1 ms.
//   Gating runs either one-shot (started by i_start) or back to back
//   (i_continuous). At every gate end the counts are latched and
//   o_count_valid pulses for one cycle.
//
// Ports
//   i_clk            system clock
//   i_rst            synchronous active-high reset
//   i_freq_in        asynchronous frequency inputs, bit n = channel n
//   i_gate_sel       00 = 1 s, 01 = 100 ms, 10 = 10 ms, 11 = 1 ms
//   i_continuous     1 = back-to-back gates, 0 = one-shot
//   i_start          one-shot trigger, honoured only while idle
//   o_busy           high while a gate is open
//   o_count_out      latched counts, channel n at [n*CNT_W +: CNT_W]
//   o_overflow       channel saturated during the last gate
//   o_signal_detect  last gate count was non-zero
//   o_count_valid    one-cycle pulse when new results are latched
module freq_counter_multi #(
    parameter int unsigned CLK_FREQ    = 25_000_000,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH-1:0]       i_freq_in,
    input  logic [1:0]              i_gate_sel,
    input  logic                    i_continuous,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic [NUM_CH*CNT_W-1:0] o_count_out,
    output logic [NUM_CH-1:0]       o_overflow,
    output logic [NUM_CH-1:0]       o_signal_detect,
    output logic                    o_count_valid
);

    // CLK_FREQ is a multiple of 1000, so it is never a power of two and
    // always fits in $clog2(CLK_FREQ) bits.
    localparam int unsigned TW = $clog2(CLK_FREQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        GATE
    } state_t;

    state_t state;
    state_t state_next;

    logic [TW-1:0]     timer;
    logic [TW-1:0]     gate_len;
    logic [TW-1:0]     sel_len;
    logic              gate_end;
    logic              gate_start;

    logic [NUM_CH-1:0] sync [SYNC_STAGES];
    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] rise;

    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [CNT_W-1:0]  cnt_inc [NUM_CH];
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] lost;

    // Gate length for the current selection; only sampled at a gate start.
    always_comb begin
        sel_len = TW'(CLK_FREQ);
        case (i_gate_sel)
            2'b00: sel_len = TW'(CLK_FREQ);
            2'b01: sel_len = TW'(CLK_FREQ / 10);
            2'b10: sel_len = TW'(CLK_FREQ / 100);
            2'b11: sel_len = TW'(CLK_FREQ / 1000);
            default: sel_len = TW'(CLK_FREQ);
        endcase
    end

    // Input synchronizers followed by the edge-detect history register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync[i] <= '0;
            end
            prev <= '0;
        end else begin
            sync[0] <= i_freq_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;

    // Saturating next count; an edge arriving at full scale is lost.
    always_comb begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            lost[n]    = rise[n] & (cnt[n] == CNT_MAX);
            cnt_inc[n] = (rise[n] && (cnt[n] != CNT_MAX)) ? cnt[n] + CNT_W'(1) : cnt[n];
        end
    end

    assign gate_end   = (timer == gate_len - TW'(1));
    assign gate_start = i_continuous | i_start;
    assign o_busy     = (state == GATE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (gate_start) state_next = GATE;
            GATE: if (gate_end && !i_continuous) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer           <= '0;
            gate_len        <= '0;
            ovf             <= '0;
            o_count_out     <= '0;
            o_overflow      <= '0;
            o_signal_detect <= '0;
            o_count_valid   <= 1'b0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            o_count_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gate_start) begin
                        gate_len <= sel_len;
                        timer    <= '0;
                        ovf      <= '0;
                        for (int unsigned n = 0; n < NUM_CH; n++) begin
                            cnt[n] <= '0;
                        end
                    end
                end
                GATE: begin
                    if (gate_end) begin
                        // The edge on the final cycle is folded into the latched result.
                        for (int unsigned n = 0; n < NUM_CH; n++) begin
                            o_count_out[n*CNT_W +: CNT_W] <= cnt_inc[n];
                            o_signal_detect[n]            <= (cnt_inc[n] != '0);
                        end
                        o_overflow    <= ovf | lost;
                        o_count_valid <= 1'b1;
                        if (i_continuous) begin
                            gate_len <= sel_len;
                            timer    <= '0;
                            ovf      <= '0;
                            for (int unsigned n = 0; n < NUM_CH; n++) begin
                                cnt[n] <= '0;
                            end
                        end
                    end else begin
                        timer <= timer + TW'(1);
                        ovf   <= ovf | lost;
                        for (int unsigned n = 0; n < NUM_CH; n++) begin
                            cnt[n] <= cnt_inc[n];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_counter_multi.sv
// tb_freq_counter_multi
//   Directed bench for freq_counter_multi with CLK_FREQ = 10_000, so the
//   gate lengths are 10 (1 ms), 100 (10 ms) and 1000 (100 ms) cycles.
//   A second instance with 4-bit counters shares all inputs and is only
//   examined for saturation behaviour.
module tb_freq_counter_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  freq_in;
    logic [1:0]  gate_sel;
    logic        continuous;
    logic        start;

    logic        busy;
    logic [63:0] count_out;
    logic [1:0]  overflow;
    logic [1:0]  signal_detect;
    logic        count_valid;

    logic        busy4;
    logic [7:0]  count_out4;
    logic [1:0]  overflow4;
    logic [1:0]  signal_detect4;
    logic        count_valid4;

    int total = 0;
    int bad   = 0;
    int busy_cnt;
    int valid_cnt;
    int period0 = 0;
    int ph = 0;
    int n;
    bit ok;

    freq_counter_multi #(
        .CLK_FREQ(10_000), .NUM_CH(2), .CNT_W(32), .SYNC_STAGES(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_freq_in(freq_in), .i_gate_sel(gate_sel),
        .i_continuous(continuous), .i_start(start), .o_busy(busy),
        .o_count_out(count_out), .o_overflow(overflow),
        .o_signal_detect(signal_detect), .o_count_valid(count_valid)
    );

    freq_counter_multi #(
        .CLK_FREQ(10_000), .NUM_CH(2), .CNT_W(4), .SYNC_STAGES(2)
    ) dut4 (
        .i_clk(clk), .i_rst(rst), .i_freq_in(freq_in), .i_gate_sel(gate_sel),
        .i_continuous(continuous), .i_start(start), .o_busy(busy4),
        .o_count_out(count_out4), .o_overflow(overflow4),
        .o_signal_detect(signal_detect4), .o_count_valid(count_valid4)
    );

    always #5 clk = ~clk;

    // Channel 0 square wave with period0 cycles (0 = held low); channel 1 low.
    initial begin
        freq_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (period0 == 0) begin
                freq_in = 2'b00;
            end else begin
                ph = (ph + 1) % period0;
                freq_in = {1'b0, (ph < period0 / 2)};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        if (count_valid) valid_cnt++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic wait_valid(input int bound, output int cycles, output bit found);
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < bound) begin
            step();
            cycles++;
            if (count_valid) found = 1'b1;
        end
    endtask

    initial begin
        int vals;
        int bad_gap;
        int bad_val;
        int busy_low;
        int last;

        rst = 1'b1; gate_sel = 2'b11; continuous = 1'b0; start = 1'b0;
        busy_cnt = 0; valid_cnt = 0;
        run(3);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_count", count_out, 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_detect", 64'(signal_detect), 64'd0);
        chk("reset_valid", 64'(count_valid), 64'd0);
        rst = 1'b0;

        // 1: one-shot 1 ms gate, ch0 period 2, ch1 low
        period0 = 2;
        run(10);
        busy_cnt = 0; valid_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        run(39);
        chk("t1_valid_pulses", 64'(valid_cnt), 64'd1);
        chk("t1_busy_cycles", 64'(busy_cnt), 64'd10);
        chk("t1_ch0", 64'(count_out[31:0]), 64'd5);
        chk("t1_ch1", 64'(count_out[63:32]), 64'd0);
        chk("t1_detect", 64'(signal_detect), 64'b01);
        chk("t1_overflow", 64'(overflow), 64'b00);

        // 2: 10 ms gate with period 2 -> 50 edges; 4-bit instance saturates
        gate_sel = 2'b10;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(120, n, ok);
        chk("t2_valid_seen", 64'(ok), 64'd1);
        chk("t2_ch0_32bit", 64'(count_out[31:0]), 64'd50);
        chk("t2_ch0_4bit", 64'(count_out4[3:0]), 64'd15);
        chk("t2_ch1_4bit", 64'(count_out4[7:4]), 64'd0);
        chk("t2_overflow_4bit", 64'(overflow4), 64'b01);
        chk("t2_detect_4bit", 64'(signal_detect4), 64'b01);
        chk("t2_overflow_32bit", 64'(overflow), 64'b00);

        // 3: continuous 1 ms gates, ch0 period 5
        period0 = 5;
        gate_sel = 2'b11;
        run(12);
        continuous = 1'b1;
        step();
        vals = 0; bad_gap = 0; bad_val = 0; busy_low = 0; last = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!busy) busy_low++;
            if (count_valid) begin
                vals++;
                if (last >= 0 && i - last != 10) bad_gap++;
                if (count_out[31:0] != 32'd2) bad_val++;
                last = i;
            end
        end
        chk("t3_valid_pulses", 64'(vals), 64'd6);
        chk("t3_bad_gaps", 64'(bad_gap), 64'd0);
        chk("t3_bad_counts", 64'(bad_val), 64'd0);
        chk("t3_busy_low", 64'(busy_low), 64'd0);

        // 4: switch to 100 ms mid-gate
        wait_valid(20, n, ok);
        chk("t4_sync_valid", 64'(ok), 64'd1);
        run(3);
        gate_sel = 2'b01;
        wait_valid(20, n, ok);
        chk("t4_cur_gate_len", 64'(n), 64'd7);
        chk("t4_cur_gate_ch0", 64'(count_out[31:0]), 64'd2);
        wait_valid(1100, n, ok);
        chk("t4_long_gate_len", 64'(n), 64'd1000);
        chk("t4_long_gate_ch0", 64'(count_out[31:0]), 64'd200);

        // 5: reset at timer = 5 aborts the gate
        continuous = 1'b0;
        wait_valid(1100, n, ok);
        chk("t5_drain_valid", 64'(ok), 64'd1);
        period0 = 2;
        gate_sel = 2'b11;
        run(12);
        chk("t5_idle_busy", 64'(busy), 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        run(5);
        rst = 1'b1;
        step();
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_count", count_out, 64'd0);
        chk("t5_rst_overflow", 64'(overflow), 64'd0);
        chk("t5_rst_detect", 64'(signal_detect), 64'd0);
        chk("t5_rst_valid", 64'(count_valid), 64'd0);
        rst = 1'b0;
        valid_cnt = 0; busy_cnt = 0;
        run(12);
        chk("t5_no_valid_after_rst", 64'(valid_cnt), 64'd0);
        chk("t5_no_busy_after_rst", 64'(busy_cnt), 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(20, n, ok);
        chk("t5_restart_valid", 64'(ok), 64'd1);
        chk("t5_restart_ch0", 64'(count_out[31:0]), 64'd5);

        // 6a: i_start re-pulsed mid-gate is ignored
        run(5);
        busy_cnt = 0; valid_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        run(4);
        start = 1'b1;
        step();
        start = 1'b0;
        run(30);
        chk("t6_start_valid", 64'(valid_cnt), 64'd1);
        chk("t6_start_busy", 64'(busy_cnt), 64'd10);

        // 6b: drop i_continuous mid-gate
        continuous = 1'b1;
        wait_valid(30, n, ok);
        chk("t6_cont_valid", 64'(ok), 64'd1);
        run(3);
        continuous = 1'b0;
        busy_cnt = 0; valid_cnt = 0;
        run(40);
        chk("t6_drop_valid", 64'(valid_cnt), 64'd1);
        chk("t6_drop_busy", 64'(busy_cnt), 64'd6);
        chk("t6_drop_final_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
